// File: rtl/ternary_seq_ctrl.sv
// Sequencing controller for a ternary-weight tile: loads weights once, then runs
// one or more compute passes and drains the output neurons through a select mux.
module ternary_seq_ctrl #(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8,
  parameter int unsigned WIDTH       = 2,
  localparam int unsigned IN_BITS    = $clog2(MAX_IN_LEN),
  localparam int unsigned OUT_BITS   = $clog2(MAX_OUT_LEN),
  localparam int unsigned WB         = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                ui_start,
  input  logic                ui_next,
  input  logic [OUT_BITS-1:0] ui_param,
  input  logic                ld_done,
  output logic                uo_ld_clr_n,
  output logic                uo_ld_en,
  output logic                uo_comp_en,
  output logic [OUT_BITS-1:0] uo_out_sel,
  output logic                uo_out_valid,
  output logic                uo_busy,
  output logic                uo_wvalid,
  output logic                uo_done
);

  // Watchdog is at least wide enough to count a full-array load.
  localparam int unsigned WD_NEED = $clog2(MAX_OUT_LEN * WIDTH + 5);
  localparam int unsigned WD_FULL = IN_BITS + WB + 1;
  localparam int unsigned WD_BITS = (WD_NEED > WD_FULL) ? WD_NEED : WD_FULL;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_SETTLE, S_COMPUTE, S_DRAIN, S_HOLD
  } state_t;

  state_t               r_state;
  logic [OUT_BITS-1:0]  r_cfg_out;
  logic [WD_BITS-1:0]   r_wdog;
  logic                 r_ld_clr_n;
  logic                 r_ld_en;
  logic                 r_comp_en;
  logic [OUT_BITS-1:0]  r_out_sel;
  logic                 r_out_valid;
  logic                 r_busy;
  logic                 r_wvalid;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [OUT_BITS-1:0]  w_cfg_nxt;
  logic [WD_BITS-1:0]   w_wdog_nxt;
  logic [WD_BITS-1:0]   w_wdog_inc;
  logic [WD_BITS-1:0]   w_wd_limit;
  logic [OUT_BITS-1:0]  w_sel_nxt;
  logic [OUT_BITS-1:0]  w_sel_inc;
  logic                 w_wvalid_nxt;
  logic                 w_done_nxt;
  logic                 w_ld_clr_n_nxt;
  logic                 w_ld_en_nxt;
  logic                 w_comp_en_nxt;
  logic                 w_out_valid_nxt;
  logic                 w_busy_nxt;

  assign w_wd_limit = WD_BITS'((32'(r_cfg_out) + 32'd1) * WIDTH + 32'd4);
  assign w_wdog_inc = r_wdog + WD_BITS'(1);
  assign w_sel_inc  = r_out_sel + OUT_BITS'(1);

  // Next-state logic; outputs are decoded from the next state and registered.
  always_comb begin
    w_state_nxt  = r_state;
    w_cfg_nxt    = r_cfg_out;
    w_wdog_nxt   = r_wdog;
    w_sel_nxt    = r_out_sel;
    w_wvalid_nxt = r_wvalid;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ui_start) begin
          w_state_nxt  = S_CLEAR;
          w_cfg_nxt    = ui_param;
          w_wvalid_nxt = 1'b0;
        end else if (ui_next && r_wvalid) begin
          w_state_nxt = S_COMPUTE;
          w_cfg_nxt   = ui_param;
        end
      end
      S_CLEAR: begin
        w_state_nxt = S_LOAD;
        w_wdog_nxt  = '0;
      end
      S_LOAD: begin
        if (ld_done) begin
          w_state_nxt = S_SETTLE;
          w_wdog_nxt  = '0;
        end else if (w_wdog_inc == w_wd_limit) begin
          w_state_nxt = S_IDLE;
          w_wdog_nxt  = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_wdog_nxt = w_wdog_inc;
        end
      end
      S_SETTLE: begin
        // Loader outputs settle one cycle after its done pulse.
        w_state_nxt  = S_COMPUTE;
        w_wvalid_nxt = 1'b1;
      end
      S_COMPUTE: begin
        w_state_nxt = S_DRAIN;
        w_sel_nxt   = '0;
        w_done_nxt  = (r_cfg_out == '0);
      end
      S_DRAIN: begin
        if (r_out_sel == r_cfg_out) begin
          w_state_nxt = S_HOLD;
          w_sel_nxt   = '0;
        end else begin
          w_sel_nxt  = w_sel_inc;
          w_done_nxt = (w_sel_inc == r_cfg_out);
        end
      end
      S_HOLD: begin
        if (!ui_start && !ui_next) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_ld_clr_n_nxt  = (w_state_nxt != S_CLEAR);
    w_ld_en_nxt     = (w_state_nxt == S_LOAD);
    w_comp_en_nxt   = (w_state_nxt == S_COMPUTE);
    w_out_valid_nxt = (w_state_nxt == S_DRAIN);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_IDLE) w_cfg_nxt = '0;
  end

  // State and output registers; ena=0 freezes everything but drops the strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cfg_out   <= '0;
      r_wdog      <= '0;
      r_ld_clr_n  <= 1'b0;
      r_ld_en     <= 1'b0;
      r_comp_en   <= 1'b0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_wvalid    <= 1'b0;
      r_done      <= 1'b0;
    end else if (!ena) begin
      r_ld_en   <= 1'b0;
      r_comp_en <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_out   <= (w_state_nxt == S_IDLE) ? r_cfg_out : w_cfg_nxt;
      r_wdog      <= w_wdog_nxt;
      r_ld_clr_n  <= w_ld_clr_n_nxt;
      r_ld_en     <= w_ld_en_nxt;
      r_comp_en   <= w_comp_en_nxt;
      r_out_sel   <= w_sel_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign uo_ld_clr_n  = r_ld_clr_n;
  assign uo_ld_en     = r_ld_en;
  assign uo_comp_en   = r_comp_en;
  assign uo_out_sel   = r_out_sel;
  assign uo_out_valid = r_out_valid;
  assign uo_busy      = r_busy;
  assign uo_wvalid    = r_wvalid;
  assign uo_done      = r_done;

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Directed bench for ternary_seq_ctrl: full job, repeat compute, watchdog,
// priority/hold, ena gating, mid-job reset and the single-neuron drain.
module tb_ternary_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       ui_start;
  logic       ui_next;
  logic [2:0] ui_param;
  logic       ld_done;
  logic       uo_ld_clr_n;
  logic       uo_ld_en;
  logic       uo_comp_en;
  logic [2:0] uo_out_sel;
  logic       uo_out_valid;
  logic       uo_busy;
  logic       uo_wvalid;
  logic       uo_done;

  int checks   = 0;
  int failures = 0;

  ternary_seq_ctrl #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8), .WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_start(ui_start), .ui_next(ui_next),
    .ui_param(ui_param), .ld_done(ld_done), .uo_ld_clr_n(uo_ld_clr_n),
    .uo_ld_en(uo_ld_en), .uo_comp_en(uo_comp_en), .uo_out_sel(uo_out_sel),
    .uo_out_valid(uo_out_valid), .uo_busy(uo_busy), .uo_wvalid(uo_wvalid),
    .uo_done(uo_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector: {clr_n, ld_en, comp_en, valid, sel, busy, wvalid, done}
  function automatic logic [9:0] ex(input logic clr_n, input logic ld_en,
                                    input logic comp_en, input logic valid,
                                    input logic [2:0] sel, input logic busy,
                                    input logic wvalid, input logic done);
    return {clr_n, ld_en, comp_en, valid, sel, busy, wvalid, done};
  endfunction

  task automatic chk(input string tag, input logic [9:0] exp_v);
    logic [9:0] obs;
    obs = {uo_ld_clr_n, uo_ld_en, uo_comp_en, uo_out_valid, uo_out_sel,
           uo_busy, uo_wvalid, uo_done};
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Already in LOAD: check n loader cycles, returning ld_done in the last one.
  task automatic load(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk(tag, ex(1, 1, 0, 0, 3'd0, 1, 0, 0));
      if (i == n - 1) ld_done = 1'b1;
      step();
    end
    ld_done = 1'b0;
  endtask

  // Already in first DRAIN cycle: check n select values and the final done.
  task automatic drain(input int n, input string tag);
    for (int s = 0; s < n; s++) begin
      chk(tag, ex(1, 0, 0, 1, 3'(s), 1, 1, (s == n - 1)));
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_start = 1'b0; ui_next = 1'b0;
    ui_param = 3'd0; ld_done = 1'b0;
    step(); step();
    chk("reset", ex(0, 0, 0, 0, 3'd0, 0, 0, 0));
    rst_n = 1'b1;
    step();
    chk("release_idle", ex(1, 0, 0, 0, 3'd0, 0, 0, 0));

    // ui_next without loaded weights is ignored
    ui_next = 1'b1;
    step(); chk("next_nowv_a", ex(1, 0, 0, 0, 3'd0, 0, 0, 0));
    step(); chk("next_nowv_b", ex(1, 0, 0, 0, 3'd0, 0, 0, 0));
    ui_next = 1'b0;

    // Full job, cfg_out=7, ld_done after 16 LOAD cycles
    ui_param = 3'd7; ui_start = 1'b1;
    step(); chk("full_clear", ex(0, 0, 0, 0, 3'd0, 1, 0, 0));
    ui_start = 1'b0;
    step(); load(16, "full_load");
    chk("full_settle", ex(1, 0, 0, 0, 3'd0, 1, 0, 0));
    step(); chk("full_compute", ex(1, 0, 1, 0, 3'd0, 1, 1, 0));
    step(); drain(8, "full_drain");
    chk("full_hold", ex(1, 0, 0, 0, 3'd0, 1, 1, 0));
    step(); chk("full_idle", ex(1, 0, 0, 0, 3'd0, 0, 1, 0));

    // Repeat compute with loaded weights
    ui_next = 1'b1;
    step(); chk("rep_compute", ex(1, 0, 1, 0, 3'd0, 1, 1, 0));
    ui_next = 1'b0;
    step(); drain(8, "rep_drain");
    chk("rep_hold", ex(1, 0, 0, 0, 3'd0, 1, 1, 0));
    step(); chk("rep_idle", ex(1, 0, 0, 0, 3'd0, 0, 1, 0));

    // Start wins over next; ui_param change mid-job ignored; held levels wait in HOLD
    ui_param = 3'd1; ui_start = 1'b1; ui_next = 1'b1;
    step(); chk("prio_clear", ex(0, 0, 0, 0, 3'd0, 1, 0, 0));
    ui_param = 3'd5;
    step(); load(2, "prio_load");
    chk("prio_settle", ex(1, 0, 0, 0, 3'd0, 1, 0, 0));
    step(); chk("prio_compute", ex(1, 0, 1, 0, 3'd0, 1, 1, 0));
    step(); drain(2, "prio_drain");
    for (int i = 0; i < 3; i++) begin
      chk("prio_hold", ex(1, 0, 0, 0, 3'd0, 1, 1, 0));
      step();
    end
    ui_start = 1'b0;
    step(); chk("prio_hold_next", ex(1, 0, 0, 0, 3'd0, 1, 1, 0));
    ui_next = 1'b0;
    step(); chk("prio_idle", ex(1, 0, 0, 0, 3'd0, 0, 1, 0));
    step(); chk("prio_no_retrig", ex(1, 0, 0, 0, 3'd0, 0, 1, 0));

    // ena low for 5 cycles mid-drain at out_sel=3
    ui_param = 3'd7; ui_next = 1'b1;
    step(); chk("ena_compute", ex(1, 0, 1, 0, 3'd0, 1, 1, 0));
    ui_next = 1'b0;
    step();
    for (int s = 0; s < 4; s++) begin
      chk("ena_drain_pre", ex(1, 0, 0, 1, 3'(s), 1, 1, 0));
      if (s < 3) step();
    end
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk("ena_frozen", ex(1, 0, 0, 1, 3'd3, 1, 1, 0));
    end
    ena = 1'b1;
    step();
    for (int s = 4; s < 8; s++) begin
      chk("ena_drain_post", ex(1, 0, 0, 1, 3'(s), 1, 1, (s == 7)));
      step();
    end
    chk("ena_hold", ex(1, 0, 0, 0, 3'd0, 1, 1, 0));
    step(); chk("ena_idle", ex(1, 0, 0, 0, 3'd0, 0, 1, 0));

    // Watchdog: cfg_out=3 -> abort after (3+1)*2+4 = 12 LOAD cycles
    ui_param = 3'd3; ui_start = 1'b1;
    step(); chk("wd_clear", ex(0, 0, 0, 0, 3'd0, 1, 0, 0));
    ui_start = 1'b0;
    step();
    for (int i = 0; i < 12; i++) begin
      chk("wd_load", ex(1, 1, 0, 0, 3'd0, 1, 0, 0));
      step();
    end
    chk("wd_abort_done", ex(1, 0, 0, 0, 3'd0, 0, 0, 1));
    ui_next = 1'b1;
    step(); chk("wd_idle_next_ignored", ex(1, 0, 0, 0, 3'd0, 0, 0, 0));
    ui_next = 1'b0;

    // Reset mid-LOAD abandons the job silently
    ui_param = 3'd2; ui_start = 1'b1;
    step(); chk("rst_clear", ex(0, 0, 0, 0, 3'd0, 1, 0, 0));
    ui_start = 1'b0;
    step(); chk("rst_load_a", ex(1, 1, 0, 0, 3'd0, 1, 0, 0));
    step(); chk("rst_load_b", ex(1, 1, 0, 0, 3'd0, 1, 0, 0));
    rst_n = 1'b0;
    step(); chk("rst_mid_load", ex(0, 0, 0, 0, 3'd0, 0, 0, 0));
    rst_n = 1'b1;
    step(); chk("rst_released", ex(1, 0, 0, 0, 3'd0, 0, 0, 0));
    ui_next = 1'b1;
    step(); chk("rst_next_ignored", ex(1, 0, 0, 0, 3'd0, 0, 0, 0));
    ui_next = 1'b0;
    ui_start = 1'b1;
    step(); chk("clean_clear", ex(0, 0, 0, 0, 3'd0, 1, 0, 0));
    ui_start = 1'b0;
    step(); load(4, "clean_load");
    chk("clean_settle", ex(1, 0, 0, 0, 3'd0, 1, 0, 0));
    step(); chk("clean_compute", ex(1, 0, 1, 0, 3'd0, 1, 1, 0));
    step(); drain(3, "clean_drain");
    chk("clean_hold", ex(1, 0, 0, 0, 3'd0, 1, 1, 0));
    step(); chk("clean_idle", ex(1, 0, 0, 0, 3'd0, 0, 1, 0));

    // cfg_out=0: single drain cycle with done
    ui_param = 3'd0; ui_next = 1'b1;
    step(); chk("one_compute", ex(1, 0, 1, 0, 3'd0, 1, 1, 0));
    ui_next = 1'b0;
    step(); drain(1, "one_drain");
    chk("one_hold", ex(1, 0, 0, 0, 3'd0, 1, 1, 0));
    step(); chk("one_idle", ex(1, 0, 0, 0, 3'd0, 0, 1, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ternary_seq_ctrl.md
TERNARY_SEQ_CTRL -- requirements
Module: ternary_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_IN_LEN, default 16, the number of input lanes of the ternary weight array.
REQ-002 SHALL have parameter MAX_OUT_LEN, default 8, the number of output neurons.
REQ-003 SHALL have parameter WIDTH, default 2, the bits per ternary weight.
REQ-004 SHALL have derived parameters IN_BITS=$clog2(MAX_IN_LEN), OUT_BITS=$clog2(MAX_OUT_LEN) and WB=$clog2(WIDTH).
REQ-005 SHALL have port clk, input, 1 bit, the clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port ena, input, 1 bit, the tile enable; while it is 0 all state and counters hold.
REQ-008 SHALL have port ui_start, input, 1 bit, a level request for a full job (weight load followed by one compute).
REQ-009 SHALL have port ui_next, input, 1 bit, a level request to compute one more vector using the weights already loaded.
REQ-010 SHALL have port ui_param, input, OUT_BITS bits, giving out_len-1; it is sampled into cfg_out on leaving IDLE.
REQ-011 SHALL have port ld_done, input, 1 bit, the completion pulse from the weight loader.
REQ-012 SHALL have port uo_ld_clr_n, output, 1 bit, an active-low clear of the loader counter.
REQ-013 SHALL have port uo_ld_en, output, 1 bit, the loader enable.
REQ-014 SHALL have port uo_comp_en, output, 1 bit, a one-cycle strobe that captures the MAC result.
REQ-015 SHALL have port uo_out_sel, output, OUT_BITS bits, the neuron index for the output mux.
REQ-016 SHALL have port uo_out_valid, output, 1 bit, which marks uo_out_sel as valid.
REQ-017 SHALL have port uo_busy, output, 1 bit, which is high in any state other than IDLE.
REQ-018 SHALL have port uo_wvalid, output, 1 bit, which indicates that the loaded weights are usable.
REQ-019 SHALL have port uo_done, output, 1 bit, a one-cycle pulse at job end.

Function
REQ-020 SHALL implement the FSM states IDLE, CLEAR, LOAD, SETTLE, COMPUTE, DRAIN and HOLD.
REQ-021 SHALL have all outputs registered; in every state not listed for an output, that output is 0.
REQ-022 SHALL, in IDLE: ui_start=1 -> CLEAR; otherwise ui_next=1 with uo_wvalid=1 -> COMPUTE; otherwise stay.
REQ-023 SHALL give ui_start priority over ui_next when both are 1 in the same cycle.
REQ-024 SHALL ignore ui_next while uo_wvalid=0 (stay in IDLE, no pulse).
REQ-025 SHALL, in CLEAR: uo_ld_clr_n=0 for exactly 1 cycle, uo_wvalid cleared, then -> LOAD.
REQ-026 SHALL, in LOAD: uo_ld_en=1 and the watchdog counter increments.
REQ-027 SHALL, on ld_done=1 in LOAD: -> SETTLE, with uo_ld_en=0 from the next cycle.
REQ-028 SHALL treat a watchdog count reaching (cfg_out+1)*WIDTH+4 in LOAD without ld_done as an abort: -> IDLE, uo_done pulses, uo_wvalid stays 0.
REQ-029 SHALL, in SETTLE: spend 1 cycle (the loader weights are valid one cycle after done), set uo_wvalid=1, then -> COMPUTE.
REQ-030 SHALL, in COMPUTE: uo_comp_en=1 for 1 cycle, then -> DRAIN with uo_out_sel=0.
REQ-031 SHALL, in DRAIN: uo_out_valid=1 and uo_out_sel increments each enabled cycle.
REQ-032 SHALL leave DRAIN when uo_out_sel==cfg_out: uo_done pulses in that same cycle, then -> HOLD.
REQ-033 SHALL produce a drain of cfg_out+1 cycles, including the boundary cases cfg_out=0 (1 cycle) and cfg_out=MAX_OUT_LEN-1 (no wrap past MAX_OUT_LEN-1).
REQ-034 SHALL, in HOLD: wait until ui_start=0 and ui_next=0, then -> IDLE, so that a held level request does not retrigger.
REQ-035 SHALL hold cfg_out constant from leaving IDLE until return to IDLE, so that ui_param changes mid-job are ignored.
REQ-036 SHALL, with ena=0 in any state: freeze all state and counters, hold registered outputs and force uo_ld_en=0 and uo_comp_en=0; resuming with ena=1 continues from the same state.
REQ-037 SHALL retain uo_wvalid across jobs until the next CLEAR or reset.
REQ-038 SHALL give a latency from ui_start sampled to the first uo_out_valid of 1 (CLEAR) + L (LOAD cycles, through ld_done) + 1 (SETTLE) + 1 (COMPUTE) cycles.

Reset
REQ-039 SHALL, on rst_n=0 at a clock edge: state=IDLE, cfg_out=0, counters=0, uo_ld_clr_n=0, uo_wvalid=0 and all other outputs 0, regardless of ena.
REQ-040 SHALL, on reset asserted mid-job: the job is abandoned with no uo_done pulse, and after release uo_wvalid=0.
REQ-041 SHALL, after release: uo_ld_clr_n=1 in IDLE.

Verification
REQ-042 SHALL cover a full job: cfg_out=7, ui_start pulse, ld_done returned 16 cycles after LOAD entry -> uo_ld_clr_n low for 1 cycle, uo_ld_en high for 16 cycles, SETTLE 1 cycle, uo_comp_en 1 cycle, out_sel 0..7 with valid, uo_done coincident with out_sel=7.
REQ-043 SHALL cover repeat compute: after REQ-042, pulse ui_next -> no CLEAR/LOAD, uo_comp_en on the next cycle, 8 drain cycles, uo_done; then ui_next with uo_wvalid=0 after reset -> no activity.
REQ-044 SHALL cover the watchdog: cfg_out=3, ld_done never returned -> abort after 12 LOAD cycles, uo_done pulse, uo_wvalid=0, FSM in IDLE.
REQ-045 SHALL cover priority and hold: ui_start and ui_next both held at 1 -> full job runs once and stays in HOLD until both drop, with no second job.
REQ-046 SHALL cover ena gating: ena=0 for 5 cycles mid-DRAIN at out_sel=3 -> out_sel holds at 3 and the drain completes after ena=1 with the total valid count unchanged.
REQ-047 SHALL cover reset mid-LOAD: rst_n=0 for 1 cycle -> IDLE, no uo_done, uo_wvalid=0, and a subsequent ui_start runs a clean job.
